// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline register carrying a control field and a data field
// behind a valid/ready handshake.
//
// SKID=1 adds a second (skid) entry so in_ready_PR comes straight from a flop. SKID=0 keeps
// a single entry with a combinational in_ready_PR.
//
// Ports:
//   clk_PR        clock; all state updates on the rising edge
//   rst_PR        asynchronous active-high reset
//   flush_PR      synchronous kill of held entries and of the same-cycle input
//   in_valid_PR   upstream has an entry
//   in_ready_PR   stage can accept an entry
//   in_ctrl_PR    upstream control field
//   in_data_PR    upstream data field
//   out_valid_PR  head entry valid
//   out_ready_PR  downstream consumes the head entry
//   out_ctrl_PR   head control; all zeros whenever out_valid_PR=0
//   out_data_PR   head data; holds its last value when invalid
//   stall_cnt_PR  saturating count of cycles with out_valid_PR=1 and out_ready_PR=0
module pipe_stage_reg #(
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_PR,
    input  logic              rst_PR,
    input  logic              flush_PR,
    input  logic              in_valid_PR,
    output logic              in_ready_PR,
    input  logic [CTRL_W-1:0] in_ctrl_PR,
    input  logic [DATA_W-1:0] in_data_PR,
    output logic              out_valid_PR,
    input  logic              out_ready_PR,
    output logic [CTRL_W-1:0] out_ctrl_PR,
    output logic [DATA_W-1:0] out_data_PR,
    output logic [CNT_W-1:0]  stall_cnt_PR
);

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } state_e;

    state_e              state_q, state_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                in_ready_q, in_ready_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                accept, drain;

    always_comb begin
        out_valid_PR = (state_q != StEmpty);
        in_ready_PR  = (SKID != 0) ? in_ready_q : (!out_valid_PR || out_ready_PR);
        accept       = in_valid_PR && in_ready_PR;
        drain        = out_valid_PR && out_ready_PR;
        out_ctrl_PR  = out_valid_PR ? main_ctrl_q : '0;
        out_data_PR  = main_data_q;
        stall_cnt_PR = stall_cnt_q;
    end

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        stall_cnt_d = stall_cnt_q;

        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d     = StOne;
                    main_ctrl_d = in_ctrl_PR;
                    main_data_d = in_data_PR;
                end
            end
            StOne: begin
                if (accept && drain) begin
                    main_ctrl_d = in_ctrl_PR;
                    main_data_d = in_data_PR;
                end else if (accept) begin
                    // Only reachable with SKID=1: with SKID=0 in_ready_PR is low here.
                    state_d     = StFull;
                    skid_ctrl_d = in_ctrl_PR;
                    skid_data_d = in_data_PR;
                end else if (drain) begin
                    state_d     = StEmpty;
                    main_ctrl_d = '0;
                end
            end
            StFull: begin
                if (drain) begin
                    state_d     = StOne;
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                    skid_ctrl_d = '0;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase

        // Flush discards everything, including a same-cycle accept; data is left alone.
        if (flush_PR) begin
            state_d     = StEmpty;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end

        // Registered ready looks at the next state so it never depends on out_ready_PR.
        in_ready_d = (state_d != StFull);

        if (out_valid_PR && !out_ready_PR && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_PR or posedge rst_PR) begin
        if (rst_PR) begin
            state_q     <= StEmpty;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (SKID=1, SKID=0, SKID=1 with a 4-bit counter)
// share one stimulus stream and are each compared every cycle against a FIFO-queue model.
module tb_pipe_stage_reg;

    localparam int unsigned CW = 16;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          rdy   [3];
    logic          vld   [3];
    logic [CW-1:0] octrl [3];
    logic [DW-1:0] odata [3];
    logic [15:0]   stall [3];
    logic [3:0]    stall_s;

    assign stall[2] = {12'h000, stall_s};

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) u_skid (
        .clk_PR(clk), .rst_PR(rst), .flush_PR(flush),
        .in_valid_PR(in_valid), .in_ready_PR(rdy[0]),
        .in_ctrl_PR(in_ctrl), .in_data_PR(in_data),
        .out_valid_PR(vld[0]), .out_ready_PR(out_ready),
        .out_ctrl_PR(octrl[0]), .out_data_PR(odata[0]), .stall_cnt_PR(stall[0])
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u_noskid (
        .clk_PR(clk), .rst_PR(rst), .flush_PR(flush),
        .in_valid_PR(in_valid), .in_ready_PR(rdy[1]),
        .in_ctrl_PR(in_ctrl), .in_data_PR(in_data),
        .out_valid_PR(vld[1]), .out_ready_PR(out_ready),
        .out_ctrl_PR(octrl[1]), .out_data_PR(odata[1]), .stall_cnt_PR(stall[1])
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) u_sat (
        .clk_PR(clk), .rst_PR(rst), .flush_PR(flush),
        .in_valid_PR(in_valid), .in_ready_PR(rdy[2]),
        .in_ctrl_PR(in_ctrl), .in_data_PR(in_data),
        .out_valid_PR(vld[2]), .out_ready_PR(out_ready),
        .out_ctrl_PR(octrl[2]), .out_data_PR(odata[2]), .stall_cnt_PR(stall_s)
    );

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } entry_t;

    // Model: each stage is a FIFO of capacity 2 (skid) or 1 (no skid) plus a stall count.
    entry_t      mq   [3][$];
    int unsigned mcnt [3];

    int n_tests = 0;
    int n_fail  = 0;

    bit exp_bp_rdy [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bit bp_ordy    [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    function automatic bit m_skid(input int i);
        return i != 1;
    endfunction

    function automatic int unsigned m_max(input int i);
        return (i == 2) ? 15 : 65535;
    endfunction

    function automatic bit m_ready(input int i);
        if (m_skid(i)) return mq[i].size() < 2;
        return (mq[i].size() == 0) || out_ready;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_models();
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("dut%0d.in_ready", i), 64'(rdy[i]), 64'(m_ready(i)));
            check_eq($sformatf("dut%0d.out_valid", i), 64'(vld[i]), 64'(mq[i].size() > 0));
            check_eq($sformatf("dut%0d.out_ctrl", i), 64'(octrl[i]),
                     (mq[i].size() > 0) ? 64'(mq[i][0].c) : 64'h0);
            if (mq[i].size() > 0) begin
                check_eq($sformatf("dut%0d.out_data", i), 64'(odata[i]), 64'(mq[i][0].d));
            end
            check_eq($sformatf("dut%0d.stall_cnt", i), 64'(stall[i]), 64'(mcnt[i]));
        end
    endtask

    // Apply inputs after the falling edge and compare the settled outputs.
    task automatic drive(input bit iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                         input bit ordy, input bit fl);
        @(negedge clk);
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_models();
    endtask

    // Advance the model across the next rising edge.
    task automatic tick();
        bit     acc [3];
        bit     drn [3];
        bit     stl [3];
        entry_t e;
        e.c = in_ctrl;
        e.d = in_data;
        for (int i = 0; i < 3; i++) begin
            acc[i] = in_valid && m_ready(i);
            drn[i] = (mq[i].size() > 0) && out_ready;
            stl[i] = (mq[i].size() > 0) && !out_ready;
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (flush) begin
                mq[i].delete();
            end else begin
                if (drn[i]) void'(mq[i].pop_front());
                if (acc[i]) mq[i].push_back(e);
            end
            if (stl[i] && mcnt[i] < m_max(i)) mcnt[i]++;
        end
    endtask

    // Asynchronous reset between clock edges; outputs must clear before any edge.
    task automatic do_reset();
        #1;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rst%0d.out_valid", i), 64'(vld[i]), 64'h0);
            check_eq($sformatf("rst%0d.out_ctrl", i), 64'(octrl[i]), 64'h0);
            check_eq($sformatf("rst%0d.out_data", i), 64'(odata[i]), 64'h0);
            check_eq($sformatf("rst%0d.in_ready", i), 64'(rdy[i]), 64'h1);
            check_eq($sformatf("rst%0d.stall_cnt", i), 64'(stall[i]), 64'h0);
            mq[i].delete();
            mcnt[i] = 0;
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [CW-1:0] got [$];
        logic [CW-1:0] bp_list [3];
        int            idx;

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        for (int i = 0; i < 3; i++) mcnt[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Streaming: one entry per cycle, each visible the cycle after acceptance.
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, CW'(k), $urandom, 1'b1, 1'b0);
            check_eq("stream.in_ready", 64'(rdy[0]), 64'h1);
            if (k >= 2) check_eq("stream.order", 64'(octrl[0]), 64'(k - 1));
            tick();
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        check_eq("stream.last", 64'(octrl[0]), 64'h8);
        tick();

        // Back-pressure: A, B, C with three stalled cycles.
        do_reset();
        bp_list[0] = 16'h000A;
        bp_list[1] = 16'h000B;
        bp_list[2] = 16'h000C;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            drive(idx < 3, (idx < 3) ? bp_list[idx] : '0, $urandom, bp_ordy[c], 1'b0);
            check_eq($sformatf("bp.in_ready[%0d]", c), 64'(rdy[0]), 64'(exp_bp_rdy[c]));
            if (vld[0] && out_ready) got.push_back(octrl[0]);
            if (idx < 3 && m_ready(0)) idx++;
            tick();
        end
        check_eq("bp.count", 64'(got.size()), 64'h3);
        for (int j = 0; j < 3; j++) begin
            check_eq($sformatf("bp.order[%0d]", j), 64'(got[j]), 64'(bp_list[j]));
        end
        check_eq("bp.stall_cnt", 64'(stall[0]), 64'h3);

        // Flush with the stage full and C presented.
        do_reset();
        drive(1'b1, 16'h00A1, $urandom, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h00B1, $urandom, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h00C1, $urandom, 1'b0, 1'b1);
        check_eq("flush.full_ready", 64'(rdy[0]), 64'h0);
        tick();
        drive(1'b1, 16'h00D1, $urandom, 1'b1, 1'b0);
        check_eq("flush.valid", 64'(vld[0]), 64'h0);
        check_eq("flush.ctrl", 64'(octrl[0]), 64'h0);
        tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        check_eq("flush.next", 64'(octrl[0]), 64'h00D1);
        tick();

        // SKID=0: ready follows out_ready combinationally while holding an entry.
        do_reset();
        drive(1'b1, 16'h00E1, $urandom, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        check_eq("noskid.ready_low", 64'(rdy[1]), 64'h0);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, CW'(16'h0F00 + k), $urandom, 1'b1, 1'b0);
            check_eq("noskid.ready_high", 64'(rdy[1]), 64'h1);
            check_eq("noskid.valid", 64'(vld[1]), 64'h1);
            tick();
        end

        // Saturation of the 4-bit counter; flush leaves it alone.
        do_reset();
        drive(1'b1, 16'h0051, $urandom, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        check_eq("sat.value", 64'(stall[2]), 64'hF);
        tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        check_eq("sat.after_flush", 64'(stall[2]), 64'hF);
        tick();

        // Random traffic with one reset in the middle.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            drive($urandom_range(0, 9) < 7, CW'($urandom), $urandom,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
            tick();
            if (k == 700) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
